// File: rtl/bcdsum_cristea.sv
// Two-digit BCD adder with a registered three-digit result and one cycle of latency.
// Optional invalid-digit flag `err` is enabled by defining BCDSUM_ERR_EN.
module bcdsum_cristea (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic       s2
`ifdef BCDSUM_ERR_EN
  ,
  output logic       err
`endif
);

  logic [4:0] t0, t1;
  logic [4:0] t0_adj, t1_adj;
  logic       c0;
  logic [3:0] s0_d, s1_d;
  logic       s2_d;
  logic [3:0] s0_q, s1_q;
  logic       s2_q;

  // Binary add per digit, then +6 folds a decimal overflow back into 0..9.
  always_comb begin
    t0     = {1'b0, a0} + {1'b0, b0};
    t0_adj = t0 + 5'd6;
    c0     = (t0 > 5'd9);
    s0_d   = c0 ? t0_adj[3:0] : t0[3:0];

    t1     = {1'b0, a1} + {1'b0, b1} + {4'b0, c0};
    t1_adj = t1 + 5'd6;
    s2_d   = (t1 > 5'd9);
    s1_d   = s2_d ? t1_adj[3:0] : t1[3:0];
  end

`ifdef BCDSUM_ERR_EN
  logic err_d, err_q;

  always_comb begin
    err_d = (a0 > 4'd9) || (a1 > 4'd9) || (b0 > 4'd9) || (b1 > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q  <= 4'd0;
      s1_q  <= 4'd0;
      s2_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s0_q  <= err_d ? 4'd0 : s0_d;
      s1_q  <= err_d ? 4'd0 : s1_d;
      s2_q  <= err_d ? 1'b0 : s2_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 4'd0;
      s1_q <= 4'd0;
      s2_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
`endif

  assign s0 = s0_q;
  assign s1 = s1_q;
  assign s2 = s2_q;

endmodule

// File: tb/tb_bcdsum_cristea.sv
// Self-checking bench for bcdsum_cristea: directed cases plus random digits
// checked against a decimal-arithmetic reference model.
module tb_bcdsum_cristea;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a0, a1, b0, b1;
  logic [3:0] s0, s1;
  logic       s2;
`ifdef BCDSUM_ERR_EN
  logic       err;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  bcdsum_cristea dut (
    .clk (clk),
    .rst (rst),
    .a0  (a0),
    .a1  (a1),
    .b0  (b0),
    .b1  (b1),
    .s0  (s0),
    .s1  (s1),
    .s2  (s2)
`ifdef BCDSUM_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  // Result packed as {s2, s1, s0} nibbles; invalid digits flagged via e.
  function automatic int model(input int x1, input int x0, input int y1, input int y0,
                               output bit e);
    int sum, t0, t1, c0, d0, d1, d2;
    e = (x0 > 9) || (x1 > 9) || (y0 > 9) || (y1 > 9);
    if (!e) begin
      sum = (x1 * 10 + x0) + (y1 * 10 + y0);
      return ((sum / 100) << 8) | (((sum / 10) % 10) << 4) | (sum % 10);
    end
`ifdef BCDSUM_ERR_EN
    return 0;
`else
    // Raw binary digits follow the same add-and-correct rule, unchecked.
    t0 = x0 + y0;
    c0 = (t0 > 9) ? 1 : 0;
    d0 = (t0 > 9) ? (t0 + 6) % 16 : t0;
    t1 = x1 + y1 + c0;
    d2 = (t1 > 9) ? 1 : 0;
    d1 = (t1 > 9) ? (t1 + 6) % 16 : t1;
    return (d2 << 8) | (d1 << 4) | d0;
`endif
  endfunction

  // Drive one operand set, clock it in, and compare the registered result.
  task automatic step(input string tag, input int x1, input int x0, input int y1,
                      input int y0, input bit r);
    int  exp;
    bit  e;
    a1  = 4'(x1);
    a0  = 4'(x0);
    b1  = 4'(y1);
    b0  = 4'(y0);
    rst = r;
    exp = model(x1, x0, y1, y0, e);
    if (r) begin
      exp = 0;
      e   = 1'b0;
    end
    @(posedge clk);
    #1;
    check(tag, {23'd0, s2, s1, s0}, exp);
`ifdef BCDSUM_ERR_EN
    check({tag, "_err"}, int'(err), int'(e));
`endif
  endtask

  initial begin
    int x1, x0, y1, y0;
    rst = 1'b1;
    a0 = 4'd0; a1 = 4'd0; b0 = 4'd0; b1 = 4'd0;
    #2;

    step("rst1", 9, 9, 9, 9, 1'b1);
    step("rst2", 9, 9, 9, 9, 1'b1);
    step("36p42", 3, 6, 4, 2, 1'b0);
    step("hold", 3, 6, 4, 2, 1'b0);
    step("19p01", 1, 9, 0, 1, 1'b0);
    step("69p48", 6, 9, 4, 8, 1'b0);
    step("99p99", 9, 9, 9, 9, 1'b0);
    step("midrst", 9, 9, 9, 9, 1'b1);
    step("postrst", 9, 9, 9, 9, 1'b0);
    step("00p00", 0, 0, 0, 0, 1'b0);
    step("50p50", 5, 0, 5, 0, 1'b0);
    step("a0_12", 0, 12, 0, 0, 1'b0);
    step("05p04", 0, 5, 0, 4, 1'b0);
    step("ff_ff", 15, 15, 15, 15, 1'b0);
    step("91p09", 9, 1, 0, 9, 1'b0);

    for (int i = 0; i < 300; i++) begin
      // Mostly legal digits, with occasional out-of-range nibbles.
      if ($urandom_range(0, 7) == 0) begin
        x1 = $urandom_range(0, 15); x0 = $urandom_range(0, 15);
        y1 = $urandom_range(0, 15); y0 = $urandom_range(0, 15);
      end else begin
        x1 = $urandom_range(0, 9); x0 = $urandom_range(0, 9);
        y1 = $urandom_range(0, 9); y0 = $urandom_range(0, 9);
      end
      step("rand", x1, x0, y1, y0, ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
